// File: rtl/mem_responder.sv
// Single-port memory responder on a shared bus: an address register with load/increment,
// a two-cycle read/write handshake through an IDLE/RD/WR FSM, and a gated data-out register.
module mem_responder #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     addr_load,
  input  logic                     inc,
  input  logic                     read,
  input  logic                     write,
  input  logic                     out_enable,
  input  logic [DATA_WIDTH-1:0]    bus_in,
  output logic [DATA_WIDTH-1:0]    bus_out,
  output logic                     ready,
  output logic [ADDRESS_WIDTH-1:0] addr
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0]    data_reg;
  logic                     mem_we;
  logic                     data_we;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  // Address requests take priority over accesses; RD/WR freeze everything but the FSM.
  always_comb begin
    state_next = state;
    addr_next  = addr;
    mem_we     = 1'b0;
    data_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (addr_load) begin
          addr_next = bus_in[ADDRESS_WIDTH-1:0];
        end else if (inc) begin
          addr_next = addr + 1'b1;
        end else if (write) begin
          mem_we     = 1'b1;
          state_next = WR;
        end else if (read) begin
          state_next = RD;
        end
      end
      RD: begin
        data_we    = 1'b1;
        state_next = IDLE;
      end
      WR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr     <= '0;
      data_reg <= '0;
    end else begin
      state <= state_next;
      addr  <= addr_next;
      if (data_we) begin
        data_reg <= mem[addr];
      end
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= bus_in;
    end
  end

  assign ready   = (state == IDLE);
  assign bus_out = out_enable ? data_reg : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: address load/increment, two-cycle accesses,
// request priority, reset abort and RD-phase input blocking.
module tb_mem_responder;

  logic       clk;
  logic       reset_n;
  logic       addr_load;
  logic       inc;
  logic       read;
  logic       write;
  logic       out_enable;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       ready;
  logic [3:0] addr;

  int unsigned tests_run;
  int unsigned tests_failed;

  mem_responder #(
    .ADDRESS_WIDTH(4),
    .DATA_WIDTH   (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addr_load (addr_load),
    .inc       (inc),
    .read      (read),
    .write     (write),
    .out_enable(out_enable),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .ready     (ready),
    .addr      (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    addr_load = 1'b0;
    inc       = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
  endtask

  task automatic load_addr(input logic [7:0] a);
    addr_load = 1'b1;
    bus_in    = a;
    tick();
    addr_load = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] d);
    write  = 1'b1;
    bus_in = d;
    tick();
    write = 1'b0;
    tick();
  endtask

  task automatic do_read();
    read = 1'b1;
    tick();
    read = 1'b0;
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle_inputs();
    bus_in     = 8'h00;
    out_enable = 1'b1;
    reset_n    = 1'b0;
    #3;
    chk("rst_bus_out", 32'(bus_out), 32'h00);
    chk("rst_addr",    32'(addr),    32'h0);
    chk("rst_ready",   32'(ready),   32'h1);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(ready), 32'h1);

    // Load 5, write A7, read it back
    load_addr(8'h05);
    chk("load5_addr", 32'(addr), 32'h5);
    write  = 1'b1;
    bus_in = 8'hA7;
    tick();
    write = 1'b0;
    chk("wr_ready_low", 32'(ready), 32'h0);
    tick();
    chk("wr_ready_back", 32'(ready), 32'h1);
    read = 1'b1;
    tick();
    read = 1'b0;
    chk("rd_ready_low", 32'(ready), 32'h0);
    chk("rd_data_not_yet", 32'(bus_out), 32'h00);
    tick();
    chk("rd_ready_back", 32'(ready), 32'h1);
    chk("rd_a7", 32'(bus_out), 32'hA7);
    out_enable = 1'b0;
    #1;
    chk("oe_low_zero", 32'(bus_out), 32'h00);
    out_enable = 1'b1;

    // Wrap from F to 0
    load_addr(8'h0F);
    chk("load_f", 32'(addr), 32'hF);
    do_write(8'h5A);
    inc = 1'b1;
    tick();
    inc = 1'b0;
    chk("inc_wrap", 32'(addr), 32'h0);
    do_write(8'h11);
    do_read();
    chk("rd_addr0", 32'(bus_out), 32'h11);
    load_addr(8'h0F);
    do_read();
    chk("rd_addrF_intact", 32'(bus_out), 32'h5A);

    // Priority: inc beats read/write; write beats read
    load_addr(8'h03);
    do_write(8'h77);
    read   = 1'b1;
    write  = 1'b1;
    inc    = 1'b1;
    bus_in = 8'hEE;
    tick();
    idle_inputs();
    chk("prio_inc_addr",  32'(addr),  32'h4);
    chk("prio_inc_ready", 32'(ready), 32'h1);
    read   = 1'b1;
    write  = 1'b1;
    bus_in = 8'h3C;
    tick();
    idle_inputs();
    chk("rw_is_write_ready", 32'(ready), 32'h0);
    tick();
    chk("rw_data_unchanged", 32'(bus_out), 32'h5A);
    do_read();
    chk("rd_addr4", 32'(bus_out), 32'h3C);
    load_addr(8'h03);
    do_read();
    chk("rd_addr3_intact", 32'(bus_out), 32'h77);

    // Reset mid-RD aborts the read
    load_addr(8'h05);
    read = 1'b1;
    tick();
    read = 1'b0;
    chk("mid_rd_state", 32'(ready), 32'h0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rd_rst_data",  32'(bus_out), 32'h00);
    chk("mid_rd_rst_ready", 32'(ready),   32'h1);
    chk("mid_rd_rst_addr",  32'(addr),    32'h0);
    #1;
    reset_n = 1'b1;
    tick();
    chk("abort_no_update", 32'(bus_out), 32'h00);
    chk("abort_ready",     32'(ready),   32'h1);
    load_addr(8'h05);
    do_read();
    chk("mem_survives_rst", 32'(bus_out), 32'hA7);

    // addr_load during RD is ignored
    load_addr(8'h0F);
    read = 1'b1;
    tick();
    read      = 1'b0;
    addr_load = 1'b1;
    bus_in    = 8'h02;
    tick();
    addr_load = 1'b0;
    chk("rd_block_addr", 32'(addr),    32'hF);
    chk("rd_block_data", 32'(bus_out), 32'h5A);
    chk("rd_block_ready", 32'(ready),  32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 4, SHALL set the address register width and give a memory depth of 2**ADDRESS_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the memory word, bus_in and bus_out width; DATA_WIDTH >= ADDRESS_WIDTH.
REQ-003 clk  in  1  SHALL be the sole clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 addr_load  in  1  SHALL request that the address register load from bus_in[ADDRESS_WIDTH-1:0].
REQ-006 inc  in  1  SHALL request that the address register increment by one.
REQ-007 read  in  1  SHALL request a read of mem[addr].
REQ-008 write  in  1  SHALL request a write of bus_in to mem[addr].
REQ-009 out_enable  in  1  SHALL gate the data register onto bus_out.
REQ-010 bus_in  in  DATA_WIDTH  SHALL be the shared-bus value for address load and write data.
REQ-011 bus_out  out  DATA_WIDTH  SHALL be the data register when out_enable=1, else all zeros, combinationally.
REQ-012 ready  out  1  SHALL be 1 only in state IDLE.
REQ-013 addr  out  ADDRESS_WIDTH  SHALL always show the current address register value.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RD, WR.
REQ-015 In IDLE with addr_load=1, addr SHALL load bus_in[ADDRESS_WIDTH-1:0]; the state stays IDLE.
REQ-016 In IDLE with addr_load=0 and inc=1, addr SHALL become addr+1 modulo 2**ADDRESS_WIDTH; all-ones wraps to 0.
REQ-017 In IDLE, an asserted addr_load or inc SHALL cause any read or write in the same cycle to be ignored.
REQ-018 In IDLE with no address request and write=1, mem[addr] SHALL take bus_in at that edge, and the state SHALL go to WR.
REQ-019 In IDLE with no address request, write=0 and read=1, the state SHALL go to RD.
REQ-020 With read=1 and write=1 together in IDLE, write SHALL win and the read SHALL be dropped.
REQ-021 In RD, the data register SHALL take mem[addr] at the next edge, and the state SHALL return to IDLE.
REQ-022 Read latency: read sampled at edge N gives valid data in the data register and ready=1 after edge N+1.
REQ-023 In WR, the state SHALL return to IDLE at the next edge with no other action; a write occupies two cycles.
REQ-024 In RD and WR, the block SHALL ignore addr_load, inc, read and write, and hold addr stable.
REQ-025 The data register SHALL change only in RD; writes SHALL NOT update it.
REQ-026 Back-to-back requests SHALL be accepted only in IDLE, so the peak rate is one access per two cycles.

Reset
REQ-027 While reset_n=0, and immediately on its assertion, the block SHALL set state=IDLE, addr=0, data register=0, ready=1, and bus_out=0 whatever out_enable is.
REQ-028 Reset asserted in RD or WR SHALL abort the access: no data register update, and state IDLE on release.
REQ-029 Reset SHALL NOT clear memory contents; contents are undefined until written, and writes completed before reset persist.
REQ-030 The first rising clk edge after reset_n goes high SHALL be processed normally.

Verification
REQ-031 Reset, then out_enable=1 -> bus_out=0, addr=0, ready=1.
REQ-032 addr_load with bus_in=0x05; write with bus_in=0xA7; read; out_enable=1 -> ready low for one cycle after each access, bus_out=0xA7 one cycle after the read edge.
REQ-033 addr_load with bus_in=0x0F, then inc -> addr=0x0; writing 0x11 there and reading back gives 0x11, and mem[0xF] is unchanged.
REQ-034 read, write and inc asserted together at addr=3 -> addr=4, no memory change, ready stays 1; then read and write together with bus_in=0x3C -> mem[4]=0x3C, data register unchanged.
REQ-035 read accepted, then reset_n pulsed low mid-RD -> data register=0, state IDLE, ready=1; a previously written mem value reads back intact after release.
REQ-036 read asserted, then addr_load with bus_in=0x02 asserted during RD -> the load is ignored, addr keeps its value, and data comes from the original address.
